// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions: default code parameters, FSM states and
// GF(2^m) constant-multiply helpers evaluated at elaboration.
package rs_pkg;

  localparam int unsigned RS_SYM_BW    = 8;
  localparam int unsigned RS_N_NUM     = 16;
  localparam int unsigned RS_R_NUM     = 8;
  localparam int unsigned RS_PRIM_POLY = 32'h11D;
  localparam int unsigned RS_FCR       = 0;

  localparam int unsigned GF_MAX_BW = 16;
  localparam int unsigned GF_POLY_W = GF_MAX_BW + 1;

  typedef logic [GF_MAX_BW-1:0] gf_elem_t;
  typedef logic [GF_POLY_W-1:0] gf_poly_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } rs_state_e;

  // Multiply by alpha (x) and reduce modulo the primitive polynomial.
  function automatic gf_elem_t gf_xtime(input gf_elem_t a, input int unsigned bw,
                                        input gf_poly_t poly);
    gf_poly_t t;
    gf_poly_t top;
    t   = {a, 1'b0};
    top = GF_POLY_W'(1) << bw;
    if ((t & top) != '0) t = t ^ poly;
    return t[GF_MAX_BW-1:0];
  endfunction

  // alpha^k as a field element; intended for constant arguments only.
  function automatic gf_elem_t gf_alpha_pow(input int unsigned k, input int unsigned bw,
                                            input gf_poly_t poly);
    gf_elem_t p;
    p = GF_MAX_BW'(1);
    for (int unsigned i = 0; i < k; i++) p = gf_xtime(p, bw, poly);
    return p;
  endfunction

  // a * c with c constant: shift-and-add folds into a fixed XOR network.
  function automatic gf_elem_t gf_mul_const(input gf_elem_t a, input gf_elem_t c,
                                            input int unsigned bw, input gf_poly_t poly);
    gf_elem_t r;
    gf_elem_t cs;
    r  = '0;
    cs = c;
    for (int i = 0; i < int'(GF_MAX_BW); i++) begin
      r = gf_xtime(r, bw, poly);
      if (cs[GF_MAX_BW-1]) r = r ^ a;
      cs = cs << 1;
    end
    return r;
  endfunction

  // LSB position of S_j inside the flattened syndrome vector.
  function automatic int unsigned synd_lsb(input int unsigned j, input int unsigned bw);
    return j * bw;
  endfunction

endpackage

// File: rtl/rs_synd_cell.sv
// One Horner accumulator for a single syndrome: load / multiply-accumulate by
// alpha^ROOT_EXP / hold. acc_next_c exposes the value being written this cycle.
module rs_synd_cell
  import rs_pkg::*;
#(
  parameter int unsigned SYM_BW    = RS_SYM_BW,
  parameter int unsigned PRIM_POLY = RS_PRIM_POLY,
  parameter int unsigned ROOT_EXP  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [SYM_BW-1:0] din,
  output logic [SYM_BW-1:0] acc_next_c
);

  localparam gf_poly_t POLY = GF_POLY_W'(PRIM_POLY);
  localparam gf_elem_t ROOT = gf_alpha_pow(ROOT_EXP, SYM_BW, POLY);

  logic [SYM_BW-1:0] acc_q;
  logic [SYM_BW-1:0] acc_d;
  logic [SYM_BW-1:0] mac_c;

  always_comb begin
    mac_c = SYM_BW'(gf_mul_const(GF_MAX_BW'(acc_q), ROOT, SYM_BW, POLY)) ^ din;
    acc_d = acc_q;
    if (load)      acc_d = din;
    else if (step) acc_d = mac_c;
  end

  assign acc_next_c = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/rs_syndrome_gen.sv
// Framed RS syndrome generator: R_NUM Horner cells plus frame control.
// Optional length/abort checking is enabled by defining RS_SYND_ERRCHK_EN.
module rs_syndrome_gen
  import rs_pkg::*;
#(
  parameter int unsigned SYM_BW    = RS_SYM_BW,
  parameter int unsigned N_NUM     = RS_N_NUM,
  parameter int unsigned R_NUM     = RS_R_NUM,
  parameter int unsigned PRIM_POLY = RS_PRIM_POLY,
  parameter int unsigned FCR       = RS_FCR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_val,
  input  logic                     din_sop,
  input  logic                     din_eop,
  input  logic [SYM_BW-1:0]        din,
  output logic                     syndrome_val,
  output logic [SYM_BW*R_NUM-1:0]  syndrome,
  output logic                     syndrome_zero,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int unsigned CNT_W  = $clog2(N_NUM + 2);
  localparam int unsigned SYND_W = SYM_BW * R_NUM;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_NUM);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_NUM + 1);

  rs_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              syndrome_val_q, syndrome_val_d;
  logic [SYND_W-1:0] syndrome_q, syndrome_d;
  logic              syndrome_zero_q, syndrome_zero_d;
  logic              busy_q, busy_d;

  logic              load_c;
  logic              step_c;
  logic              report_c;
  logic [SYM_BW-1:0] acc_next_c [R_NUM];
  logic [SYND_W-1:0] synd_next_c;

`ifdef RS_SYND_ERRCHK_EN
  logic abort_q, abort_d;
  logic frame_err_q, frame_err_d;
  logic abort_set_c;
`endif

  for (genvar j = 0; j < int'(R_NUM); j++) begin : g_cell
    rs_synd_cell #(
      .SYM_BW    (SYM_BW),
      .PRIM_POLY (PRIM_POLY),
      .ROOT_EXP  (FCR + j)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .load       (load_c),
      .step       (step_c),
      .din        (din),
      .acc_next_c (acc_next_c[j])
    );
    assign synd_next_c[synd_lsb(j, SYM_BW) +: SYM_BW] = acc_next_c[j];
  end

  // Frame control; a report latches the cells' post-beat values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_c   = 1'b0;
    step_c   = 1'b0;
    report_c = 1'b0;
`ifdef RS_SYND_ERRCHK_EN
    abort_set_c = 1'b0;
`endif
    if (din_val) begin
      if (din_sop) begin
        load_c = 1'b1;
        cnt_d  = CNT_ONE;
`ifdef RS_SYND_ERRCHK_EN
        abort_set_c = (state_q == ST_ACC);
`endif
        if (din_eop) begin
          report_c = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_ACC;
        end
      end else if (state_q == ST_ACC) begin
        step_c = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        if (din_eop) begin
          report_c = 1'b1;
          state_d  = ST_IDLE;
        end
      end
    end

    syndrome_val_d  = report_c;
    syndrome_d      = report_c ? synd_next_c : syndrome_q;
    syndrome_zero_d = report_c ? (synd_next_c == '0) : syndrome_zero_q;
    busy_d          = (state_d == ST_ACC);

`ifdef RS_SYND_ERRCHK_EN
    frame_err_d = frame_err_q;
    abort_d     = abort_q | abort_set_c;
    if (report_c) begin
      frame_err_d = (cnt_d != CNT_FULL) | abort_d;
      abort_d     = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      syndrome_val_q  <= 1'b0;
      syndrome_q      <= '0;
      syndrome_zero_q <= 1'b0;
      busy_q          <= 1'b0;
`ifdef RS_SYND_ERRCHK_EN
      abort_q         <= 1'b0;
      frame_err_q     <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      syndrome_val_q  <= syndrome_val_d;
      syndrome_q      <= syndrome_d;
      syndrome_zero_q <= syndrome_zero_d;
      busy_q          <= busy_d;
`ifdef RS_SYND_ERRCHK_EN
      abort_q         <= abort_d;
      frame_err_q     <= frame_err_d;
`endif
    end
  end

  assign syndrome_val  = syndrome_val_q;
  assign syndrome      = syndrome_q;
  assign syndrome_zero = syndrome_zero_q;
  assign busy          = busy_q;
`ifdef RS_SYND_ERRCHK_EN
  assign frame_err     = frame_err_q;
`else
  assign frame_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rs_syndrome_gen.sv
// Self-checking bench for rs_syndrome_gen: frame-level reference model using
// direct polynomial evaluation S_j = sum r_i * alpha^((FCR+j)*i).
module tb_rs_syndrome_gen;

  localparam int unsigned SYM_BW    = 8;
  localparam int unsigned N_NUM     = 16;
  localparam int unsigned R_NUM     = 8;
  localparam int unsigned PRIM_POLY = 32'h11D;
  localparam int unsigned FCR       = 0;
  localparam int unsigned SYND_W    = SYM_BW * R_NUM;
  localparam int unsigned PW2       = 2 * SYM_BW;
  localparam int          ORD       = (1 << SYM_BW) - 1;
`ifdef RS_SYND_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  typedef logic [SYM_BW-1:0] sym_q_t[$];

  logic                clk = 1'b0;
  logic                rst;
  logic                din_val, din_sop, din_eop;
  logic [SYM_BW-1:0]   din;
  logic                syndrome_val;
  logic [SYND_W-1:0]   syndrome;
  logic                syndrome_zero, frame_err, busy;

  always #5 clk = ~clk;

  rs_syndrome_gen #(
    .SYM_BW(SYM_BW), .N_NUM(N_NUM), .R_NUM(R_NUM), .PRIM_POLY(PRIM_POLY), .FCR(FCR)
  ) dut (
    .clk(clk), .rst(rst), .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop),
    .din(din), .syndrome_val(syndrome_val), .syndrome(syndrome),
    .syndrome_zero(syndrome_zero), .frame_err(frame_err), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dut_pulses = 0;

  task automatic chk(input string name, input logic [SYND_W-1:0] act, input logic [SYND_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  logic [SYM_BW-1:0] alog [ORD];

  function automatic logic [SYM_BW-1:0] gf_mul(input logic [SYM_BW-1:0] a, input logic [SYM_BW-1:0] b);
    logic [PW2-1:0] p;
    p = '0;
    for (int i = 0; i < int'(SYM_BW); i++) if (b[i]) p = p ^ (PW2'(a) << i);
    for (int i = int'(PW2) - 2; i >= int'(SYM_BW); i--)
      if (p[i]) p = p ^ (PW2'(PRIM_POLY) << (i - int'(SYM_BW)));
    return p[SYM_BW-1:0];
  endfunction

  function automatic logic [SYND_W-1:0] ref_synd(input sym_q_t f);
    logic [SYND_W-1:0] v;
    logic [SYM_BW-1:0] s;
    int L;
    v = '0;
    L = f.size();
    for (int j = 0; j < int'(R_NUM); j++) begin
      s = '0;
      for (int k = 0; k < L; k++)
        s = s ^ gf_mul(f[k], alog[((int'(FCR) + j) * (L - 1 - k)) % ORD]);
      v[j*SYM_BW +: SYM_BW] = s;
    end
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  sym_q_t            fq;
  bit                m_in, m_abort;
  logic              m_val, m_zero, m_ferr, m_busy;
  logic [SYND_W-1:0] m_synd;
  int                m_pulses = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      m_in = 0; m_abort = 0;
      m_val = 0; m_zero = 0; m_ferr = 0; m_busy = 0; m_synd = '0;
    end else begin
      m_val = 0;
      if (din_val) begin
        if (din_sop) begin
          if (m_in) m_abort = 1;
          fq.delete();
          fq.push_back(din);
          m_in = 1;
        end else if (m_in) begin
          fq.push_back(din);
        end
        if (m_in && din_eop) begin
          m_synd = ref_synd(fq);
          m_val  = 1;
          m_zero = (m_synd == '0);
          m_ferr = ERRCHK && ((fq.size() != int'(N_NUM)) || m_abort);
          m_abort = 0;
          m_in = 0;
          m_pulses++;
        end
      end
      m_busy = m_in;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      chk("syndrome_val", SYND_W'(syndrome_val), SYND_W'(m_val));
      chk("busy", SYND_W'(busy), SYND_W'(m_busy));
      chk("syndrome", syndrome, m_synd);
      chk("syndrome_zero", SYND_W'(syndrome_zero), SYND_W'(m_zero));
      chk("frame_err", SYND_W'(frame_err), SYND_W'(m_ferr));
      if (syndrome_val) dut_pulses++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input logic [SYM_BW-1:0] s, input bit sop, input bit eop);
    @(negedge clk);
    din_val = 1'b1; din = s; din_sop = sop; din_eop = eop;
  endtask

  task automatic gap();
    @(negedge clk);
    din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = SYM_BW'($urandom);
  endtask

  task automatic send(input sym_q_t f, input int ngaps, input bit with_sop, input bit with_eop);
    int left;
    int L;
    left = ngaps;
    L = f.size();
    for (int k = 0; k < L; k++) begin
      while (k > 0 && left > 0 && ($urandom_range(0, 1) == 1 || (L - k) <= left)) begin
        gap();
        left--;
      end
      beat(f[k], with_sop && (k == 0), with_eop && (k == L - 1));
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  function automatic sym_q_t randf(input int L);
    sym_q_t q;
    for (int i = 0; i < L; i++) q.push_back(SYM_BW'($urandom));
    return q;
  endfunction

  function automatic sym_q_t zeros(input int L);
    sym_q_t q;
    for (int i = 0; i < L; i++) q.push_back('0);
    return q;
  endfunction

  sym_q_t            f, g;
  logic [SYND_W-1:0] expv;
  int                p0;

  initial begin
    alog[0] = SYM_BW'(1);
    for (int i = 1; i < ORD; i++) alog[i] = gf_mul(alog[i-1], SYM_BW'(2));
    rst = 1'b1; din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    chk("rst_val", SYND_W'(syndrome_val), '0);
    chk("rst_synd", syndrome, '0);
    chk("rst_busy", SYND_W'(busy), '0);
    rst = 1'b0;
    gap();

    // All-zero codeword
    f = zeros(N_NUM);
    send(f, 0, 1, 1);
    settle();
    chk("zero_lat", SYND_W'(syndrome_val), SYND_W'(1));
    chk("zero_synd", syndrome, '0);
    chk("zero_flag", SYND_W'(syndrome_zero), SYND_W'(1));
    chk("zero_ferr", SYND_W'(frame_err), '0);
    gap();

    // r_0 = 0x5A: every syndrome equals 0x5A
    f = zeros(N_NUM);
    f[N_NUM-1] = SYM_BW'(8'h5A);
    send(f, 0, 1, 1);
    settle();
    for (int j = 0; j < int'(R_NUM); j++) expv[j*SYM_BW +: SYM_BW] = SYM_BW'(8'h5A);
    chk("r0_synd", syndrome, expv);
    chk("r0_flag", SYND_W'(syndrome_zero), '0);
    gap();

    // r_15 = 0x01: S_0 = 1, S_1 = alpha^15 = 0x26
    f = zeros(N_NUM);
    f[0] = SYM_BW'(1);
    send(f, 0, 1, 1);
    settle();
    chk("r15_s0", SYND_W'(syndrome[7:0]), SYND_W'(8'h01));
    chk("r15_s1", SYND_W'(syndrome[15:8]), SYND_W'(8'h26));
    chk("r15_ferr", SYND_W'(frame_err), '0);
    gap();

    // Back-to-back frames, three gaps inside the first
    f = randf(N_NUM);
    g = randf(N_NUM);
    p0 = dut_pulses;
    send(f, 3, 1, 1);
    send(g, 0, 1, 1);
    settle();
    chk("b2b_synd", syndrome, ref_synd(g));
    gap();
    repeat (2) @(negedge clk);
    chk("b2b_pulses", SYND_W'(dut_pulses - p0), SYND_W'(2));

    // Short 12-symbol frame
    send(randf(12), 0, 1, 1);
    settle();
    chk("short_ferr", SYND_W'(frame_err), SYND_W'(ERRCHK));
    gap();

    // sop at symbol 7 then a full frame: single report
    p0 = dut_pulses;
    g = randf(N_NUM);
    send(randf(7), 1, 1, 0);
    send(g, 0, 1, 1);
    settle();
    chk("abort_ferr", SYND_W'(frame_err), SYND_W'(ERRCHK));
    chk("abort_synd", syndrome, ref_synd(g));
    gap();
    repeat (2) @(negedge clk);
    chk("abort_pulses", SYND_W'(dut_pulses - p0), SYND_W'(1));

    // Next good frame clears frame_err
    send(randf(N_NUM), 2, 1, 1);
    settle();
    chk("good_ferr", SYND_W'(frame_err), '0);

    // One-symbol frames back to back
    p0 = dut_pulses;
    for (int i = 0; i < 3; i++) beat(SYM_BW'(8'hA0 + i), 1'b1, 1'b1);
    settle();
    for (int j = 0; j < int'(R_NUM); j++) expv[j*SYM_BW +: SYM_BW] = SYM_BW'(8'hA2);
    chk("one_synd", syndrome, expv);
    chk("one_pulses", SYND_W'(dut_pulses - p0), SYND_W'(3));
    gap();

    // Over-long 20-symbol frame (counter saturates)
    send(randf(20), 1, 1, 1);
    settle();
    chk("long_ferr", SYND_W'(frame_err), SYND_W'(ERRCHK));
    gap();

    // Reset at symbol 9: frame lost, remainder ignored
    f = randf(N_NUM);
    p0 = dut_pulses;
    send(f[0:8], 0, 1, 0);
    @(negedge clk);
    rst = 1'b1; din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    #1;
    chk("mid_rst_val", SYND_W'(syndrome_val), '0);
    chk("mid_rst_synd", syndrome, '0);
    chk("mid_rst_zero", SYND_W'(syndrome_zero), '0);
    chk("mid_rst_ferr", SYND_W'(frame_err), '0);
    chk("mid_rst_busy", SYND_W'(busy), '0);
    @(negedge clk);
    rst = 1'b0;
    send(f[9:$], 0, 0, 1);
    gap();
    repeat (2) @(negedge clk);
    chk("mid_rst_pulses", SYND_W'(dut_pulses - p0), '0);
    g = randf(N_NUM);
    send(g, 1, 1, 1);
    settle();
    chk("post_rst_synd", syndrome, ref_synd(g));
    gap();

    // Randomised soak: mixed lengths, gaps, aborts, back-to-back
    for (int it = 0; it < 40; it++) begin
      int mode;
      int L;
      mode = int'($urandom_range(0, 9));
      if (mode < 6) L = int'(N_NUM);
      else if (mode < 8) L = int'($urandom_range(1, N_NUM + 6));
      else begin
        send(randf(int'($urandom_range(1, N_NUM - 1))), 0, 1, 0);
        L = int'(N_NUM);
      end
      send(randf(L), int'($urandom_range(0, 2)), 1, 1);
      if ($urandom_range(0, 2) == 0) gap();
    end
    gap();
    repeat (3) @(negedge clk);
    chk("soak_pulses", SYND_W'(dut_pulses), SYND_W'(m_pulses));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
